// File: rtl/rdsnap32_pkg.sv
// Shared types and constants for the rdsnap32 coherent-read block.
// The timeout limit applies only when RDSNAP32_TIMEOUT_EN is defined.
package rdsnap32_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/snap_reg32.sv
// 32-bit load-enable snapshot register with synchronous clear.
// Clear takes priority over load.
module snap_reg32 (
  input  logic        sys_clk,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge sys_clk) begin
    if (clear)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/rdsnap32.sv
// Coherent 32-bit read through a 16-bit port using a snapshot register.
// Optional hold timeout is enabled by defining RDSNAP32_TIMEOUT_EN.
module rdsnap32
  import rdsnap32_pkg::*;
(
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [31:0] d,
  input  logic        rd_req,
  input  logic        rd_word,
  input  logic        flush,
  output logic [15:0] dout,
  output logic        ack,
  output logic        held,
  output logic        stale
);

  state_t      state;
  state_t      state_next;
  logic        snap_load;
  logic [31:0] snap;
  logic [15:0] dout_next;
  logic        expire;

  snap_reg32 u_snap (
    .sys_clk (sys_clk),
    .clear   (reset),
    .load    (snap_load),
    .d       (d),
    .q       (snap)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= IDLE;
      dout  <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_next;
      dout  <= dout_next;
      ack   <= rd_req;
    end
  end

  always_comb begin
    state_next = state;
    snap_load  = 1'b0;
    dout_next  = dout;
    if (rd_req && !rd_word) begin
      snap_load  = 1'b1;
      dout_next  = d[31:16];
      state_next = HELD;
    end else if (rd_req) begin
      // A flush in the same cycle discards the snapshot, so serve live data
      if (state == HELD && !flush)
        dout_next = snap[15:0];
      else
        dout_next = d[15:0];
      state_next = IDLE;
    end else if (flush || expire) begin
      state_next = IDLE;
    end
  end

  assign held = (state == HELD);

`ifdef RDSNAP32_TIMEOUT_EN
  logic [7:0] cnt;

  assign expire = (state == HELD) && (cnt == TIMEOUT_LIMIT)
                  && !rd_req && !flush;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt   <= '0;
      stale <= 1'b0;
    end else begin
      stale <= expire;
      if (snap_load || state_next != HELD)
        cnt <= '0;
      else
        cnt <= cnt + 8'd1;
    end
  end
`else
  assign expire = 1'b0;
  assign stale  = 1'b0;
`endif

endmodule
